// File: rtl/cc_branch_unit.sv
// cc_branch_unit
// Condition-code and branch-enable unit for the LC-3 datapath.
// Decodes N/Z/P (plus optional V/C) from the bus word into a flag register,
// resolves the IR branch mask against the registered flags into BEN, and
// provides a small LIFO so interrupt entry / RTI microcode can save and
// restore the flags. Stack errors (push when full, pop when empty) are sticky
// until ERR_CLR.
module cc_branch_unit #(
    parameter int DATA_W    = 16,
    parameter int EXT_FLAGS = 1,
    parameter int STK_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic [2:0]        IR_cond,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              CC_PUSH,
    input  logic              CC_POP,
    input  logic              ERR_CLR,
    output logic [2:0]        NZP,
    output logic [1:0]        VC,
    output logic              BEN,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_ovf,
    output logic              stk_udf
);

    // Depth counts 0..STK_DEPTH inclusive, so it needs one more code than
    // the memory index does.
    localparam int PTR_W = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_MAX = PTR_W'(STK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Each stack entry is {n, z, p, v, c}.
    logic [4:0]       stk_mem [STK_DEPTH];
    logic [PTR_W-1:0] depth;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic [4:0]       cur_entry;
    logic [4:0]       top_entry;

    logic             dec_n;
    logic             dec_z;
    logic             dec_p;
    logic [1:0]       dec_vc;

    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             set_ovf;
    logic             set_udf;

    // Flag decode from the word currently on the bus.
    always_comb begin
        dec_n  = bus_data[DATA_W-1];
        dec_z  = (bus_data == '0);
        dec_p  = ~dec_n & ~dec_z;
        dec_vc = (EXT_FLAGS != 0) ? {alu_v, alu_c} : 2'b00;
    end

    // Stack addressing and occupancy. top_idx wraps when empty, but it is
    // only consumed by a pop or swap, which both require a non-empty stack.
    always_comb begin
        wr_idx    = IDX_W'(depth);
        top_idx   = IDX_W'(depth - PTR_ONE);
        cur_entry = {NZP, VC};
        top_entry = stk_mem[top_idx];
        stk_full  = (depth == DEPTH_MAX);
        stk_empty = (depth == '0);
    end

    // Decode the push/pop strobes into exactly one stack action or error.
    always_comb begin
        do_push = CC_PUSH & ~CC_POP & ~stk_full;
        set_ovf = CC_PUSH & ~CC_POP &  stk_full;
        do_pop  = CC_POP  & ~CC_PUSH & ~stk_empty;
        do_swap = CC_PUSH &  CC_POP  & ~stk_empty;
        set_udf = CC_POP  &  stk_empty;
    end

    // Flag register: a restore from the stack takes precedence over LD_CC.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            NZP <= 3'b000;
            VC  <= 2'b00;
        end else if (do_pop || do_swap) begin
            NZP <= top_entry[4:2];
            VC  <= (EXT_FLAGS != 0) ? top_entry[1:0] : 2'b00;
        end else if (LD_CC) begin
            NZP <= {dec_n, dec_z, dec_p};
            VC  <= dec_vc;
        end
    end

    // Branch enable is resolved against the flags as they stand this cycle,
    // so a simultaneous LD_CC does not affect it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BEN <= 1'b0;
        end else if (LD_BEN) begin
            BEN <= |(IR_cond & NZP);
        end
    end

    // Stack depth; a swap leaves it unchanged and errors never move it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + PTR_ONE;
        end else if (do_pop) begin
            depth <= depth - PTR_ONE;
        end
    end

    // Stack storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            stk_mem[wr_idx] <= cur_entry;
        end else if (do_swap) begin
            stk_mem[top_idx] <= cur_entry;
        end
    end

    // Sticky error bits; a new error in the same cycle as ERR_CLR wins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stk_ovf <= 1'b0;
            stk_udf <= 1'b0;
        end else begin
            if (set_ovf) begin
                stk_ovf <= 1'b1;
            end else if (ERR_CLR) begin
                stk_ovf <= 1'b0;
            end
            if (set_udf) begin
                stk_udf <= 1'b1;
            end else if (ERR_CLR) begin
                stk_udf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cc_branch_unit.sv
// Testbench for cc_branch_unit: directed vectors with hand-computed expected
// outputs pushed into a scoreboard queue; a monitor pops and compares them
// on the falling edge. dut0 has extended flags, dut1 has them disabled; both
// receive the same stimulus.
module tb_cc_branch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] bus_data;
    logic        alu_c, alu_v;
    logic [2:0]  IR_cond;
    logic        LD_CC, LD_BEN, CC_PUSH, CC_POP, ERR_CLR;

    logic [2:0]  nzp0, nzp1;
    logic [1:0]  vc0, vc1;
    logic        ben0, ben1, full0, full1, empty0, empty1;
    logic        ovf0, ovf1, udf0, udf1;

    logic [9:0]  obs0, obs1;
    assign obs0 = {nzp0, vc0, ben0, full0, empty0, ovf0, udf0};
    assign obs1 = {nzp1, vc1, ben1, full1, empty1, ovf1, udf1};

    typedef struct packed {
        logic       sel;
        logic [9:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 Clk = ~Clk;

    cc_branch_unit #(.DATA_W(16), .EXT_FLAGS(1), .STK_DEPTH(4)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus_data(bus_data), .alu_c(alu_c), .alu_v(alu_v),
        .IR_cond(IR_cond), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH),
        .CC_POP(CC_POP), .ERR_CLR(ERR_CLR), .NZP(nzp0), .VC(vc0), .BEN(ben0),
        .stk_full(full0), .stk_empty(empty0), .stk_ovf(ovf0), .stk_udf(udf0)
    );

    cc_branch_unit #(.DATA_W(16), .EXT_FLAGS(0), .STK_DEPTH(4)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus_data(bus_data), .alu_c(alu_c), .alu_v(alu_v),
        .IR_cond(IR_cond), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH),
        .CC_POP(CC_POP), .ERR_CLR(ERR_CLR), .NZP(nzp1), .VC(vc1), .BEN(ben1),
        .stk_full(full1), .stk_empty(empty1), .stk_ovf(ovf1), .stk_udf(udf1)
    );

    task automatic expect_out(input string nm, input logic sel, input logic [2:0] nzp,
                              input logic [1:0] vc, input logic ben, input logic full,
                              input logic empty, input logic ovf, input logic udf);
        exp_t e;
        e.sel = sel;
        e.val = {nzp, vc, ben, full, empty, ovf, udf};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp0(input string nm, input logic [2:0] nzp, input logic [1:0] vc,
                        input logic ben, input logic full, input logic empty,
                        input logic ovf, input logic udf);
        expect_out(nm, 1'b0, nzp, vc, ben, full, empty, ovf, udf);
    endtask

    task automatic exp1(input string nm, input logic [2:0] nzp, input logic [1:0] vc,
                        input logic ben, input logic full, input logic empty,
                        input logic ovf, input logic udf);
        expect_out(nm, 1'b1, nzp, vc, ben, full, empty, ovf, udf);
    endtask

    // One clock of stimulus: drive on the falling edge, release just after the rising edge.
    task automatic cyc(input logic [15:0] bus, input logic c, input logic v,
                       input logic [2:0] cond, input logic ldcc, input logic ldben,
                       input logic push, input logic pop, input logic clr);
        @(negedge Clk);
        bus_data = bus; alu_c = c; alu_v = v; IR_cond = cond;
        LD_CC = ldcc; LD_BEN = ldben; CC_PUSH = push; CC_POP = pop; ERR_CLR = clr;
        @(posedge Clk);
        #1;
        bus_data = 16'h0; alu_c = 1'b0; alu_v = 1'b0; IR_cond = 3'b000;
        LD_CC = 1'b0; LD_BEN = 1'b0; CC_PUSH = 1'b0; CC_POP = 1'b0; ERR_CLR = 1'b0;
    endtask

    // Monitor: compare every queued expectation against the selected DUT.
    exp_t       mon_e;
    string      mon_nm;
    logic [9:0] mon_got;
    initial begin
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0) begin
                mon_e   = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                mon_got = mon_e.sel ? obs1 : obs0;
                checks++;
                if (mon_got !== mon_e.val) begin
                    errors++;
                    $display("FAIL %s dut%0d {nzp,vc,ben,full,empty,ovf,udf} got=%b expected=%b",
                             mon_nm, mon_e.sel, mon_got, mon_e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        bus_data = 16'h0; alu_c = 1'b0; alu_v = 1'b0; IR_cond = 3'b000;
        LD_CC = 1'b0; LD_BEN = 1'b0; CC_PUSH = 1'b0; CC_POP = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        exp0("reset0", 3'b000, 2'b00, 0, 0, 1, 0, 0);
        exp1("reset1", 3'b000, 2'b00, 0, 0, 1, 0, 0);

        //   bus       c  v  cond    ldcc ldben push pop clr
        cyc(16'h8000, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_neg",   3'b100, 2'b01, 0, 0, 1, 0, 0);
        exp1("ldcc_neg_x0",3'b100, 2'b00, 0, 0, 1, 0, 0);
        cyc(16'h0000, 0, 1, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_zero",  3'b010, 2'b10, 0, 0, 1, 0, 0);
        cyc(16'h0000, 0, 0, 3'b010, 0, 1, 0, 0, 0);
        exp0("ben_z",      3'b010, 2'b10, 1, 0, 1, 0, 0);
        cyc(16'h0001, 0, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_pos",   3'b001, 2'b00, 1, 0, 1, 0, 0);
        cyc(16'hFFFF, 0, 0, 3'b100, 1, 1, 0, 0, 0);
        exp0("ben_preupd", 3'b100, 2'b00, 0, 0, 1, 0, 0);

        // Fill the stack with four distinct flag sets.
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("push1",      3'b100, 2'b00, 0, 0, 0, 0, 0);
        cyc(16'h0000, 1, 1, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_z_vc11",3'b010, 2'b11, 0, 0, 0, 0, 0);
        exp1("ldcc_vc_x0", 3'b010, 2'b00, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("push2",      3'b010, 2'b11, 0, 0, 0, 0, 0);
        cyc(16'h0005, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_p_vc01",3'b001, 2'b01, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("push3",      3'b001, 2'b01, 0, 0, 0, 0, 0);
        cyc(16'h8001, 0, 1, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_n_vc10",3'b100, 2'b10, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("push4_full", 3'b100, 2'b10, 0, 1, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("push5_ovf",  3'b100, 2'b10, 0, 1, 0, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("ldcc_pre_pop",3'b010, 2'b00, 0, 1, 0, 1, 0);

        // Drain in reverse order, then underflow.
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop1",       3'b100, 2'b10, 0, 0, 0, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop2",       3'b001, 2'b01, 0, 0, 0, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop3",       3'b010, 2'b11, 0, 0, 0, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop4_empty", 3'b100, 2'b00, 0, 0, 1, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop5_udf",   3'b100, 2'b00, 0, 0, 1, 1, 1);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        exp0("err_clr",    3'b100, 2'b00, 0, 0, 1, 0, 0);

        // Swap and pop-over-load priority.
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("swap_push",  3'b100, 2'b00, 0, 0, 0, 0, 0);
        cyc(16'h0001, 0, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("swap_ldcc",  3'b001, 2'b00, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 1, 0);
        exp0("swap",       3'b100, 2'b00, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 1, 0, 0, 1, 0);
        exp0("pop_over_ld",3'b001, 2'b00, 0, 0, 1, 0, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 1, 0);
        exp0("swap_empty", 3'b001, 2'b00, 0, 0, 1, 0, 1);

        // BEN mask extremes.
        cyc(16'h0000, 0, 0, 3'b111, 0, 1, 0, 0, 0);
        exp0("ben_111",    3'b001, 2'b00, 1, 0, 1, 0, 1);
        cyc(16'h0000, 0, 0, 3'b000, 0, 1, 0, 0, 0);
        exp0("ben_000",    3'b001, 2'b00, 0, 0, 1, 0, 1);

        // Push with LD_CC captures the pre-update flags.
        cyc(16'h0000, 1, 1, 3'b000, 1, 0, 1, 0, 0);
        exp0("push_ldcc",  3'b010, 2'b11, 0, 0, 0, 0, 1);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        exp0("pop_preupd", 3'b001, 2'b00, 0, 0, 1, 0, 1);

        // Error clear versus a simultaneous new error.
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 1, 1);
        exp0("clr_vs_udf", 3'b001, 2'b00, 0, 0, 1, 0, 1);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        exp0("clr_udf",    3'b001, 2'b00, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
            exp0($sformatf("refill%0d", i), 3'b001, 2'b00, 0, (i == 4), 0, 0, 0);
        end
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 0);
        exp0("refill_ovf", 3'b001, 2'b00, 0, 1, 0, 1, 0);
        cyc(16'h0000, 0, 0, 3'b000, 0, 0, 1, 0, 1);
        exp0("clr_vs_ovf", 3'b001, 2'b00, 0, 1, 0, 1, 0);
        exp1("clr_vs_ovf_x0", 3'b001, 2'b00, 0, 1, 0, 1, 0);

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        @(posedge Clk);
        #2 Reset = 1'b1;
        exp0("async_rst",  3'b000, 2'b00, 0, 0, 1, 0, 0);
        exp1("async_rst_x0", 3'b000, 2'b00, 0, 0, 1, 0, 0);
        @(negedge Clk);
        #1 Reset = 1'b0;

        cyc(16'hFFFE, 0, 0, 3'b000, 1, 0, 0, 0, 0);
        exp0("post_rst_ld",3'b100, 2'b00, 0, 0, 1, 0, 0);

        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
